// File: rtl/pipe_addsub_pkg.sv
// ---------------------------------------------------------------------------
// pipe_addsub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   - default operand width and pipeline depth
//   - add/sub mode encoding (value of the 'sub' input)
//   - chunk width helper and configuration legality check, both evaluated
//     at elaboration time by the top level
// ---------------------------------------------------------------------------
package pipe_addsub_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,   // A + B + cin
        MODE_SUB = 1'b1    // A + ~B + 1
    } mode_e;

    // Bits rippled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // The datapath splits evenly into chunks only for these configurations.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// ---------------------------------------------------------------------------
// addsub_chunk
// Combinational CW-bit ripple chain of full adders.
// Ports:
//   a, b      CW-bit operand chunks (b already inverted for subtract)
//   ci        carry into bit 0
//   s         CW-bit chunk sum
//   co        carry out of bit CW-1
//   c_msb_in  carry into bit CW-1 (with co, gives signed overflow)
// ---------------------------------------------------------------------------
module addsub_chunk #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    // c[i] is the carry into bit i; c[CW] is the carry out of the chunk.
    logic [CW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CW; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[CW];
    assign c_msb_in = c[CW - 1];

endmodule

// File: rtl/pipe_addsub.sv
// ---------------------------------------------------------------------------
// pipe_addsub
// Pipelined ripple-carry adder/subtractor. Stage k ripples operand chunk k
// with the carry registered by stage k-1; finished low result chunks and
// not-yet-consumed high operand chunks travel alongside in skew registers.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   operand handshake
//   a, b, cin, sub       operands, carry-in (add only), mode (1 = A-B)
//   out_valid, out_ready result handshake
//   sum, cout, ovf       result, carry out of MSB (sub: 1 = no borrow),
//                        two's-complement overflow
//
// Handshake: a beat transfers on a rising edge where valid && ready. The
// whole pipeline moves on one enable, adv = !out_valid || out_ready; when
// adv is 0 every stage holds, so the output beat stays stable while it is
// not taken. in_ready equals adv and is combinational from out_valid and
// out_ready. Empty stages (bubbles) shift like full ones.
// ---------------------------------------------------------------------------
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             adv;
    mode_e            mode;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract is A + ~B + 1, so cin is replaced by a forced carry.
    assign mode  = mode_e'(sub);
    assign b_eff = (mode == MODE_SUB) ? ~b : b;
    assign c_eff = (mode == MODE_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OPW = WIDTH - k * CW;  // operand bits still unconsumed on entry
        localparam int SW  = (k + 1) * CW;    // result bits known on exit

        logic [OPW-1:0] op_a;
        logic [OPW-1:0] op_b;
        logic           op_c;
        logic           op_v;
        logic [CW-1:0]  ch_s;
        logic           ch_co;
        logic [SW-1:0]  s_d;

        logic           v_q;
        logic           c_q;
        logic [SW-1:0]  s_q;

        if (k == 0) begin : g_src
            assign op_a = a;
            assign op_b = b_eff;
            assign op_c = c_eff;
            assign op_v = in_valid;
            assign s_d  = ch_s;
        end else begin : g_src
            assign op_a = g_stage[k-1].g_mid.a_q;
            assign op_b = g_stage[k-1].g_mid.b_q;
            assign op_c = g_stage[k-1].c_q;
            assign op_v = g_stage[k-1].v_q;
            assign s_d  = {ch_s, g_stage[k-1].s_q};
        end

        if (k == STAGES - 1) begin : g_last
            logic msb_ci;
            logic ovf_q;

            addsub_chunk #(.CW(CW)) u_chunk (
                .a        (op_a[CW-1:0]),
                .b        (op_b[CW-1:0]),
                .ci       (op_c),
                .s        (ch_s),
                .co       (ch_co),
                .c_msb_in (msb_ci)
            );

            // Overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= msb_ci ^ ch_co;
                end
            end
        end else begin : g_mid
            localparam int RW = OPW - CW;
            // Only the top chunk's MSB carry contributes to overflow.
            logic          msb_ci_unused;
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;

            addsub_chunk #(.CW(CW)) u_chunk (
                .a        (op_a[CW-1:0]),
                .b        (op_b[CW-1:0]),
                .ci       (op_c),
                .s        (ch_s),
                .co       (ch_co),
                .c_msb_in (msb_ci_unused)
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= op_a[OPW-1:CW];
                    b_q <= op_b[OPW-1:CW];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= op_v;
                c_q <= ch_co;
                s_q <= s_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipe_addsub
// Directed and randomized stimulus for pipe_addsub (WIDTH=64, STAGES=4).
// Expected beats are {cout, ovf, sum}, taken either from literal values or
// from a reference model using plain signed/unsigned arithmetic.
// ---------------------------------------------------------------------------
module tb_pipe_addsub;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset / DUT ----------------
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] a         = '0;
    logic [63:0] b         = '0;
    logic        cin       = 1'b0;
    logic        sub       = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [65:0] exp_q[$];
    bit          rand_ready = 1'b0;
    int          valid_run  = 0;
    int          max_run    = 0;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed result decides overflow, unsigned result decides
    // sum and carry; subtract carry means "no borrow", i.e. x >= y.
    function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic s);
        logic signed [65:0] sx;
        logic signed [65:0] sy;
        logic signed [65:0] sr;
        logic        [64:0] ur;
        logic               co;
        logic               ov;
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        if (s) begin
            sr = sx - sy;
            ur = {1'b0, x} - {1'b0, y};
            co = (x >= y);
        end else begin
            sr = sx + sy + {65'b0, ci};
            ur = {1'b0, x} + {1'b0, y} + {64'b0, ci};
            co = ur[64];
        end
        ov = (sr[64] != sr[63]);
        return {co, ov, ur[63:0]};
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = ALL1;
            1:       v = '0;
            2:       v = MINS;
            3:       v = MAXS;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
            if (exp_q.size() == 0) begin
                check("out_unexpected", 66'(out_valid), 66'(0));
            end else begin
                check("out_beat", {cout, ovf, sum}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            valid_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left just after a rising edge.
    task automatic drive_beat(input logic [63:0] x, input logic [63:0] y,
                              input logic ci, input logic s, input logic [65:0] e);
        bit took;
        took     = 1'b0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                took = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (took) exp_q.push_back(e);
        else check("accept_timeout", 66'(took), 66'(1));
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 66'(exp_q.size()), 66'(0));
        @(posedge clk); #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          lat;
        logic [63:0] x;
        logic [63:0] y;
        logic        ci;
        logic        s;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out_valid", 66'(out_valid), 66'(0));
        check("reset_sum",       66'(sum),       66'(0));
        check("reset_cout",      66'(cout),      66'(0));
        check("reset_ovf",       66'(ovf),       66'(0));
        check("reset_in_ready",  66'(in_ready),  66'(1));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Add wrap and latency
        drive_beat(ALL1, 64'd1, 1'b0, 1'b0, {1'b1, 1'b0, 64'h0});
        idle();
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 66'(lat), 66'(STAGES));
        @(posedge clk); #1;
        wait_drain();

        // Subtract with borrow (cin ignored)
        drive_beat(64'd0, 64'd1, 1'b1, 1'b1, {1'b0, 1'b0, ALL1});
        // Signed overflow, add and subtract
        drive_beat(MAXS, 64'd1, 1'b0, 1'b0, {1'b0, 1'b1, MINS});
        drive_beat(MINS, 64'd1, 1'b0, 1'b1, {1'b1, 1'b1, MAXS});
        idle();
        wait_drain();

        // Streaming: 8 back-to-back beats
        max_run = 0;
        for (int i = 1; i <= 8; i++) begin
            x = 64'(i);
            y = x << 32;
            drive_beat(x, y, 1'b0, 1'b0, {2'b00, x + y});
        end
        idle();
        wait_drain();
        check("stream_run", 66'(max_run), 66'(8));

        // Back-pressure: fill the pipeline with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            x  = {$urandom(), $urandom()};
            y  = {$urandom(), $urandom()};
            ci = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            drive_beat(x, y, ci, s, model(x, y, ci, s));
        end
        // Offer one more beat that must not be taken while stalled.
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h0FED_CBA9_8765_4321;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  66'(in_ready),  66'(0));
            check("bp_out_valid", 66'(out_valid), 66'(1));
            @(posedge clk); #1;
        end
        idle();
        out_ready = 1'b1;
        wait_drain();

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            x = pick();
            y = pick();
            drive_beat(x, y, 1'b1, 1'b0, model(x, y, 1'b1, 1'b0));
        end
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 66'(out_valid), 66'(0));
        check("midrst_sum",       66'(sum),       66'(0));
        check("midrst_cout",      66'(cout),      66'(0));
        check("midrst_ovf",       66'(ovf),       66'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 66'(out_valid), 66'(0));
        end
        @(posedge clk); #1;
        drive_beat(64'd5, 64'd7, 1'b1, 1'b0, {2'b00, 64'd13});
        idle();
        wait_drain();

        // Randomized traffic with random back-pressure and input gaps
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            x  = pick();
            y  = pick();
            ci = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            drive_beat(x, y, ci, s, model(x, y, ci, s));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
